// File: rtl/execute_muldiv_if.sv
// execute_muldiv_if: request/response bundle between Execute and the multiply/divide unit
interface execute_muldiv_if #(
  parameter int XLEN = 32,
  parameter int TAG_WIDTH = 5
);
  logic flush;
  logic start;
  logic [2:0] op;
  logic [XLEN-1:0] operandA;
  logic [XLEN-1:0] operandB;
  logic [TAG_WIDTH-1:0] tagIn;
  logic busy;
  logic done;
  logic [XLEN-1:0] result;
  logic [TAG_WIDTH-1:0] tagOut;
  modport master (
    output flush, start, op, operandA, operandB, tagIn,
    input busy, done, result, tagOut
  );
  modport slave (
    input flush, start, op, operandA, operandB, tagIn,
    output busy, done, result, tagOut
  );
endinterface

// File: rtl/execute_muldiv.sv
// execute_muldiv: multi-cycle RV32M/RV64M multiply (fixed-latency pipeline) and restoring divide unit
module execute_muldiv #(
  parameter int XLEN = 32,
  parameter int DIV_BITS = 1,
  parameter int MUL_LATENCY = 2,
  parameter int TAG_WIDTH = 5
) (
  input logic clock,
  input logic reset,
  execute_muldiv_if.slave bus
);
  localparam int ITERS = XLEN / DIV_BITS;
  localparam int STAGES = MUL_LATENCY > 1 ? MUL_LATENCY - 1 : 1;
  localparam int CW = $clog2(ITERS + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state;
  logic [2:0] opReg;
  logic [TAG_WIDTH-1:0] tagReg;
  logic [CW-1:0] count;
  logic [XLEN-1:0] remReg, quoReg, divisorReg;
  logic quoNeg, remNeg;
  logic [2*XLEN-1:0] product;
  logic [2*XLEN-1:0] pipe [STAGES];
  logic aExt, bExt, divSigned, negA, negB, divByZero, overflow, fits;
  logic [XLEN-1:0] absA, absB, fastResult, stepRem, stepQuo, stepDivisor, quoFixed, remFixed;
  logic [XLEN:0] trial;

  function automatic logic [XLEN-1:0] mulPick(input logic [2*XLEN-1:0] p, input logic [2:0] o);
    return o[1:0] == 2'b00 ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  // Sign-extended full-width product of the issuing operands (MULH: both signed, MULHSU: A only)
  assign aExt = (bus.op[1] ^ bus.op[0]) & bus.operandA[XLEN-1];
  assign bExt = (bus.op[1:0] == 2'b01) & bus.operandB[XLEN-1];
  assign product = {{XLEN{aExt}}, bus.operandA} * {{XLEN{bExt}}, bus.operandB};

  assign divSigned = ~bus.op[0];
  assign negA = divSigned & bus.operandA[XLEN-1];
  assign negB = divSigned & bus.operandB[XLEN-1];
  assign absA = negA ? -bus.operandA : bus.operandA;
  assign absB = negB ? -bus.operandB : bus.operandB;
  assign divByZero = bus.operandB == '0;
  assign overflow = divSigned && (bus.operandA == MIN_INT) && (&bus.operandB);
  assign fastResult = divByZero ? (bus.op[1] ? bus.operandA : '1) : (bus.op[1] ? '0 : bus.operandA);
  assign quoFixed = quoNeg ? -quoReg : quoReg;
  assign remFixed = remNeg ? -remReg : remReg;

  // Free-running product delay line; the FSM picks the stage that lines up with the accepted start
  always_ff @(posedge clock) begin
    pipe[0] <= product;
    for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
  end

  // DIV_BITS restoring steps; in IDLE the first step is seeded straight from the issuing operands
  always_comb begin
    stepRem = state == IDLE ? '0 : remReg;
    stepQuo = state == IDLE ? absA : quoReg;
    stepDivisor = state == IDLE ? absB : divisorReg;
    trial = '0;
    fits = 1'b0;
    for (int i = 0; i < DIV_BITS; i++) begin
      trial = {stepRem, stepQuo[XLEN-1]};
      fits = trial >= {1'b0, stepDivisor};
      stepQuo = {stepQuo[XLEN-2:0], fits};
      stepRem = fits ? XLEN'(trial - {1'b0, stepDivisor}) : trial[XLEN-1:0];
    end
  end

  // Control FSM with registered busy/done/result/tagOut; flush always wins
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.result <= '0;
      bus.tagOut <= '0;
    end else begin
      bus.done <= 1'b0;
      if (bus.flush) begin
        state <= IDLE;
        bus.busy <= 1'b0;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            opReg <= bus.op;
            tagReg <= bus.tagIn;
            if (!bus.op[2]) begin
              if (MUL_LATENCY == 1) begin
                bus.result <= mulPick(product, bus.op);
                bus.tagOut <= bus.tagIn;
                bus.done <= 1'b1;
              end else begin
                state <= MUL;
                bus.busy <= 1'b1;
                count <= '0;
              end
            end else if (divByZero || overflow) begin
              bus.result <= fastResult;
              bus.tagOut <= bus.tagIn;
              bus.done <= 1'b1;
            end else begin
              state <= DIV;
              bus.busy <= 1'b1;
              count <= CW'(1);
              remReg <= stepRem;
              quoReg <= stepQuo;
              divisorReg <= absB;
              quoNeg <= negA ^ negB;
              remNeg <= negA;
            end
          end
          MUL: if (count == CW'(MUL_LATENCY - 2)) begin
            state <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.result <= mulPick(pipe[STAGES-1], opReg);
            bus.tagOut <= tagReg;
          end else begin
            count <= count + 1'b1;
          end
          DIV: begin
            remReg <= stepRem;
            quoReg <= stepQuo;
            count <= count + 1'b1;
            if (count == CW'(ITERS - 1)) state <= FIX;
          end
          default: begin
            state <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.result <= opReg[1] ? remFixed : quoFixed;
            bus.tagOut <= tagReg;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_execute_muldiv.sv
// tb_execute_muldiv: directed and reference-model checks of execute_muldiv at default and wide parameters
module tb_execute_muldiv;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    logic [2:0] op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int cyc;
  } vec_t;

  execute_muldiv_if #(.XLEN(32), .TAG_WIDTH(5)) m32();
  execute_muldiv_if #(.XLEN(64), .TAG_WIDTH(5)) m64();

  execute_muldiv dut32 (.clock(clock), .reset(reset), .bus(m32.slave));
  execute_muldiv #(.XLEN(64), .DIV_BITS(4), .MUL_LATENCY(4), .TAG_WIDTH(5))
    dut64 (.clock(clock), .reset(reset), .bus(m64.slave));

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [63:0] model64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb, p;
    logic [127:0] ua, ub;
    logic ovf;
    sa = $signed(a);
    sb = $signed(b);
    ua = {64'b0, a};
    ub = {64'b0, b};
    ovf = (a == 64'h8000000000000000) && (b == '1);
    case (op)
      3'd0: return a * b;
      3'd1: begin p = sa * sb; return p[127:64]; end
      3'd2: begin p = sa * $signed(ub); return p[127:64]; end
      3'd3: begin p = ua * ub; return p[127:64]; end
      3'd4: return b == 0 ? '1 : ovf ? a : 64'($signed(a) / $signed(b));
      3'd5: return b == 0 ? '1 : a / b;
      3'd6: return b == 0 ? a : ovf ? '0 : 64'($signed(a) % $signed(b));
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  task automatic issue(input bit w, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tag, output logic [63:0] res, output logic [4:0] tg, output int cyc);
    @(posedge clock); #1;
    if (w) begin
      m64.start = 1; m64.op = op; m64.operandA = a; m64.operandB = b; m64.tagIn = tag;
    end else begin
      m32.start = 1; m32.op = op; m32.operandA = a[31:0]; m32.operandB = b[31:0]; m32.tagIn = tag;
    end
    cyc = -1;
    res = '0;
    tg = '0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clock); #1;
      m32.start = 0;
      m64.start = 0;
      if (w ? m64.done : m32.done) begin
        cyc = i;
        res = w ? m64.result : {32'b0, m32.result};
        tg = w ? m64.tagOut : m32.tagOut;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic seen;
    reset = 1;
    m32.flush = 0; m64.flush = 0;
    m32.start = 1; m32.op = 0; m32.operandA = 7; m32.operandB = 6; m32.tagIn = 3;
    m64.start = 1; m64.op = 4; m64.operandA = 9; m64.operandB = 0; m64.tagIn = 3;
    repeat (3) @(posedge clock);
    #1;
    reset = 0;
    m32.start = 0;
    m64.start = 0;
    vectors += 4;
    if (m32.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy32: got %b want 0", m32.busy); end
    if (m32.done !== 1'b0) begin miscompares++; $display("FAIL reset_done32: got %b want 0", m32.done); end
    if (m32.result !== 32'h0) begin miscompares++; $display("FAIL reset_result32: got %h want 0", m32.result); end
    if (m32.tagOut !== 5'h0) begin miscompares++; $display("FAIL reset_tag32: got %h want 0", m32.tagOut); end
    vectors += 2;
    if (m64.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy64: got %b want 0", m64.busy); end
    if (m64.result !== 64'h0) begin miscompares++; $display("FAIL reset_result64: got %h want 0", m64.result); end
    seen = 0;
    repeat (5) begin
      @(posedge clock); #1;
      seen |= m32.done | m64.done;
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL reset_no_done: got done %b want 0", seen); end
  endtask

  task automatic test_mul();
    logic [63:0] res;
    logic [4:0] tg;
    int cyc;
    vec_t t[4] = '{
      '{3'd1, 64'h80000000, 64'h80000000, 64'h40000000, 2},
      '{3'd3, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 2},
      '{3'd2, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 2},
      '{3'd0, 64'd7, 64'd6, 64'd42, 2}
    };
    foreach (t[i]) begin
      issue(0, t[i].op, t[i].a, t[i].b, 5'(i + 17), res, tg, cyc);
      vectors += 3;
      if (res !== t[i].exp) begin miscompares++; $display("FAIL mul[%0d] result: got %h want %h", i, res, t[i].exp); end
      if (cyc !== t[i].cyc) begin miscompares++; $display("FAIL mul[%0d] cycle: got %0d want %0d", i, cyc, t[i].cyc); end
      if (tg !== 5'(i + 17)) begin miscompares++; $display("FAIL mul[%0d] tag: got %0d want %0d", i, tg, i + 17); end
    end
  endtask

  task automatic test_div();
    logic [63:0] res;
    logic [4:0] tg;
    int cyc;
    vec_t t[4] = '{
      '{3'd4, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 33},
      '{3'd6, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFF, 33},
      '{3'd5, 64'd100, 64'd7, 64'd14, 33},
      '{3'd7, 64'd100, 64'd7, 64'd2, 33}
    };
    foreach (t[i]) begin
      issue(0, t[i].op, t[i].a, t[i].b, 5'(i + 1), res, tg, cyc);
      vectors += 3;
      if (res !== t[i].exp) begin miscompares++; $display("FAIL div[%0d] result: got %h want %h", i, res, t[i].exp); end
      if (cyc !== t[i].cyc) begin miscompares++; $display("FAIL div[%0d] cycle: got %0d want %0d", i, cyc, t[i].cyc); end
      if (tg !== 5'(i + 1)) begin miscompares++; $display("FAIL div[%0d] tag: got %0d want %0d", i, tg, i + 1); end
    end
  endtask

  task automatic test_fast_path();
    logic [63:0] res;
    logic [4:0] tg;
    int cyc;
    vec_t t[8] = '{
      '{3'd4, 64'd5, 64'd0, 64'hFFFFFFFF, 1},
      '{3'd6, 64'd5, 64'd0, 64'd5, 1},
      '{3'd5, 64'd9, 64'd0, 64'hFFFFFFFF, 1},
      '{3'd7, 64'd9, 64'd0, 64'd9, 1},
      '{3'd4, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1},
      '{3'd6, 64'h80000000, 64'hFFFFFFFF, 64'h0, 1},
      '{3'd5, 64'h80000000, 64'hFFFFFFFF, 64'h0, 33},
      '{3'd7, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 33}
    };
    foreach (t[i]) begin
      issue(0, t[i].op, t[i].a, t[i].b, 5'(i + 8), res, tg, cyc);
      vectors += 3;
      if (res !== t[i].exp) begin miscompares++; $display("FAIL fast[%0d] result: got %h want %h", i, res, t[i].exp); end
      if (cyc !== t[i].cyc) begin miscompares++; $display("FAIL fast[%0d] cycle: got %0d want %0d", i, cyc, t[i].cyc); end
      if (tg !== 5'(i + 8)) begin miscompares++; $display("FAIL fast[%0d] tag: got %0d want %0d", i, tg, i + 8); end
    end
  endtask

  task automatic test_flush();
    logic [63:0] res;
    logic [4:0] tg;
    int cyc;
    logic seen;
    issue(0, 3'd0, 64'd7, 64'd6, 5'd2, res, tg, cyc);
    vectors++;
    if (res !== 64'd42) begin miscompares++; $display("FAIL flush_setup: got %h want 2a", res); end
    @(posedge clock); #1;
    m32.start = 1; m32.op = 5; m32.operandA = 100; m32.operandB = 7; m32.tagIn = 11;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clock); #1;
      m32.start = 0;
    end
    vectors++;
    if (m32.busy !== 1'b1) begin miscompares++; $display("FAIL flush_busy_c10: got %b want 1", m32.busy); end
    m32.flush = 1;
    @(posedge clock); #1;
    m32.flush = 0;
    vectors++;
    if (m32.busy !== 1'b0) begin miscompares++; $display("FAIL flush_busy_c11: got %b want 0", m32.busy); end
    seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      seen |= m32.done;
    end
    vectors += 3;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL flush_no_done: got %b want 0", seen); end
    if (m32.result !== 32'd42) begin miscompares++; $display("FAIL flush_result_held: got %h want 2a", m32.result); end
    if (m32.tagOut !== 5'd2) begin miscompares++; $display("FAIL flush_tag_held: got %0d want 2", m32.tagOut); end
    m32.start = 1; m32.op = 3; m32.operandA = '1; m32.operandB = '1; m32.tagIn = 12;
    @(posedge clock); #1;
    m32.start = 0;
    m32.flush = 1;
    @(posedge clock); #1;
    m32.flush = 0;
    vectors += 2;
    if (m32.done !== 1'b0) begin miscompares++; $display("FAIL flush_suppress_done: got %b want 0", m32.done); end
    if (m32.busy !== 1'b0) begin miscompares++; $display("FAIL flush_suppress_busy: got %b want 0", m32.busy); end
    m32.start = 1; m32.flush = 1; m32.op = 0;
    @(posedge clock); #1;
    m32.start = 0;
    m32.flush = 0;
    vectors++;
    if (m32.busy !== 1'b0) begin miscompares++; $display("FAIL flush_with_start: got busy %b want 0", m32.busy); end
    seen = 0;
    repeat (4) begin
      @(posedge clock); #1;
      seen |= m32.done;
    end
    vectors += 2;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL flush_late_done: got %b want 0", seen); end
    if (m32.result !== 32'd42) begin miscompares++; $display("FAIL flush_result_final: got %h want 2a", m32.result); end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    logic seen;
    @(posedge clock); #1;
    m32.start = 1; m32.op = 5; m32.operandA = 100; m32.operandB = 7; m32.tagIn = 3;
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clock); #1;
      m32.start = (i == 5);
      if (i == 5) begin m32.op = 0; m32.operandA = 7; m32.operandB = 6; m32.tagIn = 9; end
      if (m32.done) begin cyc = i; break; end
    end
    m32.start = 0;
    vectors += 3;
    if (cyc !== 33) begin miscompares++; $display("FAIL ignore_cycle: got %0d want 33", cyc); end
    if (m32.result !== 32'd14) begin miscompares++; $display("FAIL ignore_result: got %h want e", m32.result); end
    if (m32.tagOut !== 5'd3) begin miscompares++; $display("FAIL ignore_tag: got %0d want 3", m32.tagOut); end
    seen = 0;
    repeat (6) begin
      @(posedge clock); #1;
      seen |= m32.done;
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL ignore_extra_done: got %b want 0", seen); end
  endtask

  task automatic test_back_to_back();
    @(posedge clock); #1;
    m32.start = 1; m32.op = 0; m32.operandA = 7; m32.operandB = 6; m32.tagIn = 4;
    @(posedge clock); #1;
    m32.start = 0;
    vectors++;
    if (m32.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy_c1: got %b want 1", m32.busy); end
    @(posedge clock); #1;
    vectors += 4;
    if (m32.done !== 1'b1) begin miscompares++; $display("FAIL b2b_done_c2: got %b want 1", m32.done); end
    if (m32.busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_c2: got %b want 0", m32.busy); end
    if (m32.result !== 32'd42) begin miscompares++; $display("FAIL b2b_result1: got %h want 2a", m32.result); end
    if (m32.tagOut !== 5'd4) begin miscompares++; $display("FAIL b2b_tag1: got %0d want 4", m32.tagOut); end
    m32.start = 1; m32.op = 3; m32.operandA = '1; m32.operandB = '1; m32.tagIn = 5;
    @(posedge clock); #1;
    m32.start = 0;
    vectors += 2;
    if (m32.done !== 1'b0) begin miscompares++; $display("FAIL b2b_done_c3: got %b want 0", m32.done); end
    if (m32.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy_c3: got %b want 1", m32.busy); end
    @(posedge clock); #1;
    vectors += 3;
    if (m32.done !== 1'b1) begin miscompares++; $display("FAIL b2b_done_c4: got %b want 1", m32.done); end
    if (m32.result !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL b2b_result2: got %h want fffffffe", m32.result); end
    if (m32.tagOut !== 5'd5) begin miscompares++; $display("FAIL b2b_tag2: got %0d want 5", m32.tagOut); end
  endtask

  task automatic test_wide();
    logic [63:0] res;
    logic [4:0] tg;
    int cyc;
    vec_t t[3] = '{
      '{3'd5, 64'h8000000000000000, 64'd3, 64'h2AAAAAAAAAAAAAAA, 17},
      '{3'd3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 4},
      '{3'd4, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1}
    };
    foreach (t[i]) begin
      issue(1, t[i].op, t[i].a, t[i].b, 5'(i + 20), res, tg, cyc);
      vectors += 3;
      if (res !== t[i].exp) begin miscompares++; $display("FAIL wide[%0d] result: got %h want %h", i, res, t[i].exp); end
      if (cyc !== t[i].cyc) begin miscompares++; $display("FAIL wide[%0d] cycle: got %0d want %0d", i, cyc, t[i].cyc); end
      if (tg !== 5'(i + 20)) begin miscompares++; $display("FAIL wide[%0d] tag: got %0d want %0d", i, tg, i + 20); end
    end
  endtask

  task automatic test_random_wide();
    logic [63:0] res, a, b, exp;
    logic [2:0] op;
    logic [4:0] tg;
    int cyc, expCyc;
    for (int i = 0; i < 20; i++) begin
      op = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 5 == 0) b = '0;
      if (i % 5 == 1) begin a = 64'h8000000000000000; b = '1; end
      if (i % 5 == 2) b = ($urandom_range(0, 1) == 1) ? -64'($urandom_range(1, 15)) : 64'($urandom_range(1, 15));
      exp = model64(op, a, b);
      expCyc = op < 4 ? 4 : (b == 0 || (op[0] == 1'b0 && a == 64'h8000000000000000 && b == '1)) ? 1 : 17;
      issue(1, op, a, b, 5'(i), res, tg, cyc);
      vectors += 2;
      if (res !== exp) begin miscompares++; $display("FAIL rand[%0d] op %0d %h,%h result: got %h want %h", i, op, a, b, res, exp); end
      if (cyc !== expCyc) begin miscompares++; $display("FAIL rand[%0d] cycle: got %0d want %0d", i, cyc, expCyc); end
    end
  endtask

  initial begin
    m32.flush = 0; m32.start = 0; m32.op = 0; m32.operandA = 0; m32.operandB = 0; m32.tagIn = 0;
    m64.flush = 0; m64.start = 0; m64.op = 0; m64.operandA = 0; m64.operandB = 0; m64.tagIn = 0;
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_flush();
    test_busy_ignore();
    test_back_to_back();
    test_wide();
    test_random_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
